// File: rtl/trigger_sequencer.sv
// Multi-level trigger sequencer: a 16-level state machine that steps through
// configured levels on qualified hit occurrences, takes an else branch on
// timer expiry, issues timer commands, and fires a one-cycle run pulse.
module trigger_sequencer (
    input  logic        clk,
    input  logic        reset,
    input  logic        wrenb,
    input  logic [3:0]  wraddr,
    input  logic [31:0] config_data,
    input  logic        arm,
    input  logic        sample_valid,
    input  logic [3:0]  hit,
    input  logic [1:0]  timer_elapsed,
    output logic        update_timers,
    output logic [1:0]  fsm_start_timer,
    output logic [1:0]  fsm_stop_timer,
    output logic [1:0]  fsm_clear_timer,
    output logic        run,
    output logic        capture,
    output logic [3:0]  level,
    output logic        active
);

    typedef enum logic [1:0] {
        PH_IDLE   = 2'd0,
        PH_ACTIVE = 2'd1,
        PH_FIRED  = 2'd2
    } phase_e;

    // Config storage keeps only the meaningful bits; [31:28] are reserved.
    logic [27:0] cfg_mem_q [16];
    logic        unused_cfg_s;

    assign unused_cfg_s = ^config_data[31:28];

    // Decoded fields of the current level's config word
    logic [27:0] cfg_s;
    logic [3:0]  cfg_next_s;
    logic [3:0]  cfg_else_s;
    logic [7:0]  cfg_count_s;
    logic        cfg_last_s;
    logic [1:0]  cfg_start_s;
    logic [1:0]  cfg_stop_s;
    logic [1:0]  cfg_clear_s;
    logic [1:0]  cfg_else_en_s;
    logic [1:0]  cfg_hit_sel_s;
    logic        cfg_cap_on_hit_s;

    logic        sel_hit_s;
    logic        hit_match_s;
    logic        hit_below_s;
    logic        else_take_s;

    // Sequencer state and registered outputs
    phase_e      phase_q, phase_d;
    logic [3:0]  level_q, level_d;
    logic [7:0]  count_q, count_d;
    logic        update_timers_q, update_timers_d;
    logic [1:0]  start_timer_q, start_timer_d;
    logic [1:0]  stop_timer_q, stop_timer_d;
    logic [1:0]  clear_timer_q, clear_timer_d;
    logic        run_q, run_d;
    logic        capture_q, capture_d;
    logic        active_q, active_d;

    // Config RAM write port; contents deliberately survive reset
    always_ff @(posedge clk) begin
        if (wrenb) begin
            cfg_mem_q[wraddr] <= config_data[27:0];
        end
    end

    assign cfg_s            = cfg_mem_q[level_q];
    assign cfg_next_s       = cfg_s[3:0];
    assign cfg_else_s       = cfg_s[7:4];
    assign cfg_count_s      = cfg_s[15:8];
    assign cfg_last_s       = cfg_s[16];
    assign cfg_start_s      = cfg_s[18:17];
    assign cfg_stop_s       = cfg_s[20:19];
    assign cfg_clear_s      = cfg_s[22:21];
    assign cfg_else_en_s    = cfg_s[24:23];
    assign cfg_hit_sel_s    = cfg_s[26:25];
    assign cfg_cap_on_hit_s = cfg_s[27];

    assign sel_hit_s   = hit[cfg_hit_sel_s];
    assign hit_match_s = sel_hit_s && (count_q == cfg_count_s);
    assign hit_below_s = sel_hit_s && (count_q < cfg_count_s);
    assign else_take_s = (|(timer_elapsed & cfg_else_en_s)) && !hit_match_s;

    // Next-state and next-output evaluation for one sample
    always_comb begin
        phase_d         = phase_q;
        level_d         = level_q;
        count_d         = count_q;
        update_timers_d = 1'b0;
        start_timer_d   = 2'b00;
        stop_timer_d    = 2'b00;
        clear_timer_d   = 2'b00;
        run_d           = 1'b0;
        capture_d       = 1'b0;

        if (arm) begin
            // Arm restarts the sequence and suppresses evaluation this cycle
            phase_d = PH_ACTIVE;
            level_d = 4'd0;
            count_d = 8'd0;
        end else begin
            case (phase_q)
                PH_ACTIVE: begin
                    if (sample_valid) begin
                        capture_d = !cfg_cap_on_hit_s || sel_hit_s;
                        if (hit_match_s) begin
                            count_d         = 8'd0;
                            update_timers_d = 1'b1;
                            start_timer_d   = cfg_start_s;
                            stop_timer_d    = cfg_stop_s;
                            clear_timer_d   = cfg_clear_s;
                            if (cfg_last_s) begin
                                phase_d = PH_FIRED;
                                run_d   = 1'b1;
                            end else begin
                                level_d = cfg_next_s;
                            end
                        end else if (hit_below_s) begin
                            count_d = count_q + 8'd1;
                        end else if (else_take_s) begin
                            level_d = cfg_else_s;
                            count_d = 8'd0;
                        end else begin
                            count_d = count_q;
                        end
                    end else begin
                        capture_d = 1'b0;
                    end
                end
                PH_FIRED: begin
                    capture_d = sample_valid;
                end
                PH_IDLE: begin
                    capture_d = 1'b0;
                end
                default: begin
                    phase_d = PH_IDLE;
                end
            endcase
        end
    end

    assign active_d = (phase_d == PH_ACTIVE);

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            phase_q         <= PH_IDLE;
            level_q         <= 4'd0;
            count_q         <= 8'd0;
            update_timers_q <= 1'b0;
            start_timer_q   <= 2'b00;
            stop_timer_q    <= 2'b00;
            clear_timer_q   <= 2'b00;
            run_q           <= 1'b0;
            capture_q       <= 1'b0;
            active_q        <= 1'b0;
        end else begin
            phase_q         <= phase_d;
            level_q         <= level_d;
            count_q         <= count_d;
            update_timers_q <= update_timers_d;
            start_timer_q   <= start_timer_d;
            stop_timer_q    <= stop_timer_d;
            clear_timer_q   <= clear_timer_d;
            run_q           <= run_d;
            capture_q       <= capture_d;
            active_q        <= active_d;
        end
    end

    assign update_timers   = update_timers_q;
    assign fsm_start_timer = start_timer_q;
    assign fsm_stop_timer  = stop_timer_q;
    assign fsm_clear_timer = clear_timer_q;
    assign run             = run_q;
    assign capture         = capture_q;
    assign level           = level_q;
    assign active          = active_q;

endmodule
